vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters with registered visible-area, sync and frame strobes.
// Sync outputs are pushed through a SYNC_DELAY-stage chain so they line up with a registered RGB stage downstream.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clock_25,
  input  logic       reset,
  output logic       display_area,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_start,
  output logic       vblank_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_wrap;
  logic       hsync_raw;
  logic       vsync_raw;

  always_comb begin
    x_wrap = (pixel_x == X_MAX);
    x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
    y_next = pixel_y;
    if (x_wrap) begin
      y_next = (pixel_y == Y_MAX) ? 10'd0 : pixel_y + 10'd1;
    end
  end

  // Every decode uses the next count, so the registered flags describe the same cycle as the counters.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      pixel_x      <= X_MAX;
      pixel_y      <= Y_MAX;
      display_area <= 1'b0;
      frame_start  <= 1'b0;
      vblank_tick  <= 1'b0;
      hsync_raw    <= 1'b1;
      vsync_raw    <= 1'b1;
    end else begin
      pixel_x      <= x_next;
      pixel_y      <= y_next;
      display_area <= (x_next < X_VIS) && (y_next < Y_VIS);
      frame_start  <= (x_next == 10'd0) && (y_next == 10'd0);
      vblank_tick  <= (x_next == 10'd0) && (y_next == Y_VIS);
      hsync_raw    <= !((x_next >= HS_BEG) && (x_next < HS_END));
      vsync_raw    <= !((y_next >= VS_BEG) && (y_next < VS_END));
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync_n = hsync_raw;
      assign vsync_n = vsync_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] h_dly;
      logic [SYNC_DELAY-1:0] v_dly;

      always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
          h_dly <= '1;
          v_dly <= '1;
        end else begin
          h_dly[0] <= hsync_raw;
          v_dly[0] <= vsync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            h_dly[i] <= h_dly[i-1];
            v_dly[i] <= v_dly[i-1];
          end
        end
      end

      assign hsync_n = h_dly[SYNC_DELAY-1];
      assign vsync_n = v_dly[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four instances (default timing with delays 1/0/3, plus a tiny geometry for whole frames)
// compared every cycle against a position-from-cycle-number model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       da;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
  } obs_t;

  // Geometry per instance: 0 = default/delay1, 1 = default/delay0, 2 = default/delay3, 3 = small/delay2
  int g_ha [4] = '{640, 640, 640, 8};
  int g_hf [4] = '{16, 16, 16, 2};
  int g_hs [4] = '{96, 96, 96, 3};
  int g_hb [4] = '{48, 48, 48, 2};
  int g_va [4] = '{480, 480, 480, 6};
  int g_vf [4] = '{10, 10, 10, 1};
  int g_vs [4] = '{2, 2, 2, 2};
  int g_vb [4] = '{33, 33, 33, 1};
  int g_d  [4] = '{1, 0, 3, 2};

  logic clock_25 = 1'b0;
  logic reset    = 1'b1;
  always #20 clock_25 = ~clock_25;

  logic [9:0] px [4];
  logic [9:0] py [4];
  logic       da [4];
  logic       hs [4];
  logic       vs [4];
  logic       fs [4];
  logic       vb [4];
  obs_t       act [4];

  vga_sync_gen u_d1 (
    .clock_25(clock_25), .reset(reset), .display_area(da[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .hsync_n(hs[0]), .vsync_n(vs[0]), .frame_start(fs[0]), .vblank_tick(vb[0]));

  vga_sync_gen #(.SYNC_DELAY(0)) u_d0 (
    .clock_25(clock_25), .reset(reset), .display_area(da[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .hsync_n(hs[1]), .vsync_n(vs[1]), .frame_start(fs[1]), .vblank_tick(vb[1]));

  vga_sync_gen #(.SYNC_DELAY(3)) u_d3 (
    .clock_25(clock_25), .reset(reset), .display_area(da[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .hsync_n(hs[2]), .vsync_n(vs[2]), .frame_start(fs[2]), .vblank_tick(vb[2]));

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
                 .V_BP(1), .SYNC_DELAY(2)) u_small (
    .clock_25(clock_25), .reset(reset), .display_area(da[3]), .pixel_x(px[3]), .pixel_y(py[3]),
    .hsync_n(hs[3]), .vsync_n(vs[3]), .frame_start(fs[3]), .vblank_tick(vb[3]));

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign act[g] = {px[g], py[g], da[g], hs[g], vs[g], fs[g], vb[g]};
  end

  int errors = 0;
  int checks = 0;
  int n      = -1;  // rising edges since reset release, minus one; -1 means held in reset

  // Expected outputs for instance k, n clocks after the first post-reset edge.
  function automatic obs_t model(int k, int cyc);
    obs_t o;
    int ht, vt, x, y, m, xm, ym;
    ht = g_ha[k] + g_hf[k] + g_hs[k] + g_hb[k];
    vt = g_va[k] + g_vf[k] + g_vs[k] + g_vb[k];
    if (cyc < 0) begin
      o = '{x: 10'(ht - 1), y: 10'(vt - 1), da: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0};
      return o;
    end
    x = cyc % ht;
    y = (cyc / ht) % vt;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.da = (x < g_ha[k]) && (y < g_va[k]);
    o.fs = (x == 0) && (y == 0);
    o.vb = (x == 0) && (y == g_va[k]);
    m = cyc - g_d[k];
    if (m < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      xm = m % ht;
      ym = (m / ht) % vt;
      o.hs = !((xm >= g_ha[k] + g_hf[k]) && (xm < g_ha[k] + g_hf[k] + g_hs[k]));
      o.vs = !((ym >= g_va[k] + g_vf[k]) && (ym < g_va[k] + g_vf[k] + g_vs[k]));
    end
    return o;
  endfunction

  task automatic compare_all(string tag);
    obs_t e;
    for (int k = 0; k < 4; k++) begin
      e = model(k, n);
      checks++;
      if (act[k] !== e) begin
        errors++;
        $display("FAIL %s inst%0d n=%0d: got x=%0d y=%0d da=%b hs=%b vs=%b fs=%b vb=%b, want x=%0d y=%0d da=%b hs=%b vs=%b fs=%b vb=%b",
                 tag, k, n, act[k].x, act[k].y, act[k].da, act[k].hs, act[k].vs, act[k].fs, act[k].vb,
                 e.x, e.y, e.da, e.hs, e.vs, e.fs, e.vb);
      end
    end
  endtask

  task automatic step();
    @(posedge clock_25);
    #1;
    n++;
    compare_all("cycle");
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n = -1;
    compare_all("reset_async");
    repeat (3) begin
      @(posedge clock_25);
      #1;
      compare_all("reset_hold");
    end
    reset = 1'b1;
  endtask

  task automatic test_first_edge();
    step();
    checks++;
    if (act[0].x !== 10'd0 || act[0].y !== 10'd0) begin
      errors++;
      $display("FAIL first_edge_pos: got (%0d,%0d), want (0,0)", act[0].x, act[0].y);
    end
    checks++;
    if (act[0].da !== 1'b1 || act[0].fs !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_flags: got da=%b fs=%b, want da=1 fs=1", act[0].da, act[0].fs);
    end
    checks++;
    if (act[0].hs !== 1'b1 || act[0].vs !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_sync: got hs=%b vs=%b, want 1 1", act[0].hs, act[0].vs);
    end
  endtask

  task automatic test_line();
    int da_cnt = 1;
    int fall_x [3] = '{-1, -1, -1};
    int low_cnt [3] = '{0, 0, 0};
    int want_fall [3] = '{657, 656, 659};
    logic prev [3];
    for (int k = 0; k < 3; k++) prev[k] = act[k].hs;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (i < 800) begin
        if (act[0].da === 1'b1) da_cnt++;
        for (int k = 0; k < 3; k++) begin
          if (act[k].hs === 1'b0) low_cnt[k]++;
          if (prev[k] === 1'b1 && act[k].hs === 1'b0 && fall_x[k] < 0) fall_x[k] = int'(act[k].x);
          prev[k] = act[k].hs;
        end
      end
    end
    checks++;
    if (da_cnt != 640) begin
      errors++;
      $display("FAIL line_display_count: got %0d, want 640", da_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fall_x[k] != want_fall[k]) begin
        errors++;
        $display("FAIL hsync_fall_x inst%0d: got %0d, want %0d", k, fall_x[k], want_fall[k]);
      end
      checks++;
      if (low_cnt[k] != 96) begin
        errors++;
        $display("FAIL hsync_width inst%0d: got %0d, want 96", k, low_cnt[k]);
      end
    end
    checks++;
    if (act[0].x !== 10'd0 || act[0].y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got (%0d,%0d), want (0,1)", act[0].x, act[0].y);
    end
  endtask

  // Three whole frames of the small geometry (15x10 = 150 clocks each).
  task automatic test_frames();
    int da_cnt = 0, fs_cnt = 0, vb_cnt = 0, vs_cnt = 0;
    #10 reset = 1'b0;
    #1;
    n = -1;
    compare_all("frames_reset");
    @(posedge clock_25);
    #1;
    reset = 1'b1;
    step();
    for (int i = 0; i < 450; i++) begin
      if (act[3].da === 1'b1) da_cnt++;
      if (act[3].fs === 1'b1) fs_cnt++;
      if (act[3].vb === 1'b1) vb_cnt++;
      if (act[3].vs === 1'b0) vs_cnt++;
      if (n == 149) begin
        checks++;
        if (act[3].x !== 10'd14 || act[3].y !== 10'd9) begin
          errors++;
          $display("FAIL frame_last_pos: got (%0d,%0d), want (14,9)", act[3].x, act[3].y);
        end
      end
      if (n == 150) begin
        checks++;
        if (act[3].x !== 10'd0 || act[3].y !== 10'd0 || act[3].fs !== 1'b1) begin
          errors++;
          $display("FAIL frame_wrap: got (%0d,%0d) fs=%b, want (0,0) fs=1", act[3].x, act[3].y, act[3].fs);
        end
      end
      step();
    end
    checks++;
    if (da_cnt != 144) begin
      errors++;
      $display("FAIL frame_display_count: got %0d, want 144", da_cnt);
    end
    checks++;
    if (fs_cnt != 3 || vb_cnt != 3) begin
      errors++;
      $display("FAIL frame_strobes: got fs=%0d vb=%0d, want 3 3", fs_cnt, vb_cnt);
    end
    checks++;
    if (vs_cnt != 90) begin
      errors++;
      $display("FAIL frame_vsync_width: got %0d, want 90", vs_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int run, hold;
    for (int it = 0; it < 5; it++) begin
      run  = $urandom_range(1, 400);
      hold = $urandom_range(1, 4);
      repeat (run) step();
      #10 reset = 1'b0;
      #1;
      n = -1;
      compare_all("midframe_async");
      repeat (hold) begin
        @(posedge clock_25);
        #1;
        compare_all("midframe_hold");
      end
      reset = 1'b1;
      step();
      checks++;
      if (act[0].fs !== 1'b1 || act[3].fs !== 1'b1) begin
        errors++;
        $display("FAIL midframe_restart: got fs0=%b fs3=%b, want 1 1", act[0].fs, act[3].fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_line();
    test_frames();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
